qif_spike_logger: RTL

- Downstream consumer of the QIF neuron's spike_out and V outputs.
- Detects spike events, timestamps them with a free-running counter, and computes the inter-spike interval (ISI).
- Buffers {ISI, V sample} records in a small FIFO and serializes them as bytes over a valid/ready handshake to the chip's output pins.
- Also reports a windowed spike-rate count.

---
 rtl/qif_pkg.sv | 23 ++
 rtl/qif_rec_fifo.sv | 54 +++++
 rtl/qif_spike_logger.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/qif_pkg.sv
// Shared types and constants for the QIF spike logger: record layout,
// serializer states and fixed byte values.
package qif_pkg;

  localparam int TS_W = 16;
  localparam logic [15:0] ISI_FIRST = 16'hFFFF;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef struct packed {
    logic [7:0] isi_hi;
    logic [7:0] isi_lo;
    logic [7:0] v;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_B0,
    S_B1,
    S_B2
  } state_t;

endpackage

// File: rtl/qif_rec_fifo.sv
// Small synchronous record FIFO. A push into a full FIFO is accepted when a
// pop happens in the same cycle. rst_n is an active-high asynchronous reset.
module qif_rec_fifo
  import qif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  rec_t                     din,
  output rec_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  rec_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  // DEPTH is a power of two, so the level MSB alone marks full
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qif_spike_logger.sv
// Spike event logger: timestamps spikes, computes ISI, buffers {ISI, V}
// records and serializes them bytewise; also reports a windowed spike rate.
// Define QIF_LOG_HEADER_EN to prefix every record with a sync byte.
// Note: rst_n is an asynchronous ACTIVE-HIGH reset despite its name.
module qif_spike_logger
  import qif_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_LOG2   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          spike_in,
  input  logic signed [7:0]             v_in,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    rate,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef QIF_LOG_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam logic [WIN_LOG2-1:0] WIN_ONE = 1;

  logic [TS_W-1:0] ts, last_ts, isi;
  logic            spike_q, first, evt, pop, full, empty, drop;
  rec_t            rec_in, fifo_out, hold;
  state_t          state, start_state;
  logic [7:0]      start_byte, spk_cnt, spk_next;
  logic [WIN_LOG2-1:0] win_cnt;

  assign evt      = en & spike_in & ~spike_q;
  assign isi      = first ? ISI_FIRST : ts - last_ts;
  assign rec_in   = {isi, v_in};
  assign pop      = ~empty & ((state == S_IDLE) | ((state == S_B2) & out_ready));
  assign drop     = evt & full & ~pop;
  assign spk_next = (spk_cnt == 8'hFF) ? 8'hFF : spk_cnt + 8'd1;

  // first byte of a record: sync byte when headers are enabled
  assign start_state = HDR_EN ? S_HDR : S_B0;
  assign start_byte  = HDR_EN ? SYNC_BYTE : fifo_out.isi_hi;

  qif_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt),
    .pop   (pop),
    .din   (rec_in),
    .dout  (fifo_out),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ts       <= '0;
      last_ts  <= '0;
      spike_q  <= 1'b0;
      first    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      ts      <= ts + 16'd1;
      spike_q <= spike_in;
      // ISI reference advances even when the record itself is dropped
      if (evt) begin
        last_ts <= ts;
        first   <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_cnt <= '0;
      spk_cnt <= '0;
      rate    <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_ONE;
      if (&win_cnt) begin
        rate    <= evt ? spk_next : spk_cnt;
        spk_cnt <= '0;
      end else if (evt) begin
        spk_cnt <= spk_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= S_IDLE;
      hold      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          hold      <= fifo_out;
          state     <= start_state;
          out_data  <= start_byte;
          out_valid <= 1'b1;
        end
        S_HDR: if (out_ready) begin
          state    <= S_B0;
          out_data <= hold.isi_hi;
        end
        S_B0: if (out_ready) begin
          state    <= S_B1;
          out_data <= hold.isi_lo;
        end
        S_B1: if (out_ready) begin
          state    <= S_B2;
          out_data <= hold.v;
        end
        S_B2: if (out_ready) begin
          if (!empty) begin
            hold     <= fifo_out;
            state    <= start_state;
            out_data <= start_byte;
          end else begin
            state     <= S_IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
